// File: rtl/aes_mixcolumns_multi.sv
// ---------------------------------------------------------------------------
// aes_mixcolumns_multi
//
// Purpose:
//   MixColumns / InvMixColumns stage for the AES round datapath. A 128-bit
//   state arrives as four 32-bit columns. On a rising edge of start_in it is
//   captured, then transformed COLS_PER_CYCLE columns per clock. A one-cycle
//   done pulse marks the point where all four output columns are valid.
//
// Parameters:
//   COLS_PER_CYCLE  columns transformed per clock (1, 2 or 4 only).
//                   Latency from start edge to done is 4/COLS_PER_CYCLE + 1.
//
// Configuration macro:
//   AES_MIXCOL_INV_EN  when defined, the inverse multipliers and the inv_in
//                      capture register are built, and inv_in = 1 selects
//                      InvMixColumns. When undefined only the forward
//                      transform exists and inv_in is ignored (port kept).
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   start_in            start request, an operation begins on its rising edge
//   inv_in              0 = MixColumns, 1 = InvMixColumns (sampled with state)
//   state0..state3      input columns 0..3, row 0 byte in [7:0]
//   state_out0..3       transformed columns, same byte order
//   done                one-cycle pulse when the outputs are valid
//   busy                high from capture until done
// ---------------------------------------------------------------------------
module aes_mixcolumns_multi #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_in,
  input  logic        inv_in,
  input  logic [31:0] state0,
  input  logic [31:0] state1,
  input  logic [31:0] state2,
  input  logic [31:0] state3,
  output logic [31:0] state_out0,
  output logic [31:0] state_out1,
  output logic [31:0] state_out2,
  output logic [31:0] state_out3,
  output logic        done,
  output logic        busy
);

  // Only 1, 2 and 4 divide the four columns evenly; anything else is a
  // configuration mistake and must stop elaboration.
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : gen_badParam
    $error("aes_mixcolumns_multi: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Column index step per clock and the index of the final group. The
  // index is two bits wide, so a step of 4 wraps to 0 as intended.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  // ------------------------------------------------------------------
  // GF(2^8) arithmetic, reduction polynomial x^8+x^4+x^3+x+1. Every
  // constant multiply is a chain of xtime steps; no lookup tables.
  // ------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward column: out_r = 02*a_r ^ 03*a_(r+1) ^ a_(r+2) ^ a_(r+3)
  function automatic logic [31:0] fwdColumn(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[8*r +: 8];
      x2[r] = xtime(col[8*r +: 8]);
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      res[8*r +: 8] = x2[r]
                    ^ (x2[(r+1)%4] ^ a[(r+1)%4])
                    ^ a[(r+2)%4]
                    ^ a[(r+3)%4];
    end
    return res;
  endfunction

`ifdef AES_MIXCOL_INV_EN
  // Inverse column: coefficients 0e, 0b, 0d, 09 in the same rotation.
  // Each byte is expanded once into x2/x4/x8 and the products are formed
  // by XORing those multiples together.
  function automatic logic [31:0] invColumn(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[8*r +: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      res[8*r +: 8] = (x8[r] ^ x4[r] ^ x2[r])
                    ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                    ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                    ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
    end
    return res;
  endfunction
`endif

  stateT       r_state;
  stateT       w_nextState;
  logic        r_startQ;
  logic [1:0]  r_col;
  logic [31:0] r_work [4];
  logic [31:0] r_out  [4];
  logic        r_done;
  logic        r_busy;

  logic        w_startEdge;
  logic        w_capture;
  logic        w_compute;
  logic [1:0]  w_idx [COLS_PER_CYCLE];
  logic [31:0] w_res [COLS_PER_CYCLE];

`ifdef AES_MIXCOL_INV_EN
  logic        r_inv;
`else
  logic        w_unusedInv;
  assign w_unusedInv = inv_in;
`endif

  assign w_startEdge = start_in & ~r_startQ;

  // One transform per output group. Each group works on the captured
  // copy of its column, never on the input ports.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : gen_group
    assign w_idx[g] = r_col + 2'(g);
`ifdef AES_MIXCOL_INV_EN
    assign w_res[g] = r_inv ? invColumn(r_work[w_idx[g]]) : fwdColumn(r_work[w_idx[g]]);
`else
    assign w_res[g] = fwdColumn(r_work[w_idx[g]]);
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Start edges are honoured only in IDLE; BUSY walks
  // through the column groups and DONE lasts exactly one cycle.
  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_compute   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_startEdge) begin
          w_capture   = 1'b1;
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        w_compute = 1'b1;
        if (r_col == LAST_COL) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Start edge history is tracked every cycle regardless of state, so a
  // start held high through an operation never looks like a new edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_startQ <= 1'b0;
    end else begin
      r_startQ <= start_in;
    end
  end

  // Working copy of the state, loaded only on an accepted start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_work[i] <= '0;
      end
`ifdef AES_MIXCOL_INV_EN
      r_inv <= 1'b0;
`endif
    end else if (w_capture) begin
      r_work[0] <= state0;
      r_work[1] <= state1;
      r_work[2] <= state2;
      r_work[3] <= state3;
`ifdef AES_MIXCOL_INV_EN
      r_inv <= inv_in;
`endif
    end
  end

  // Column index: cleared on capture, stepped once per compute cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
    end else if (w_capture) begin
      r_col <= '0;
    end else if (w_compute) begin
      r_col <= r_col + COL_STEP;
    end
  end

  // Output columns keep their value between operations; each compute
  // cycle overwrites only the group being processed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_out[i] <= '0;
      end
    end else if (w_compute) begin
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
        r_out[w_idx[g]] <= w_res[g];
      end
    end
  end

  // done is the registered image of the DONE state, so it appears the
  // cycle after DONE is entered; busy drops at that same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      r_busy <= (w_nextState != IDLE);
    end
  end

  assign state_out0 = r_out[0];
  assign state_out1 = r_out[1];
  assign state_out2 = r_out[2];
  assign state_out3 = r_out[3];
  assign done       = r_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_aes_mixcolumns_multi.sv
// ---------------------------------------------------------------------------
// tb_aes_mixcolumns_multi
//
// Drives three instances (COLS_PER_CYCLE = 1, 2, 4) from shared inputs and
// compares every instance with a behavioural GF(2^8) model of MixColumns.
// ---------------------------------------------------------------------------
module tb_aes_mixcolumns_multi;

`ifdef AES_MIXCOL_INV_EN
  localparam bit INV_BUILT = 1'b1;
`else
  localparam bit INV_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_in = 1'b0;
  logic        inv_in = 1'b0;
  logic [31:0] st [4];
  logic [31:0] outs [3][4];
  logic        dones [3];
  logic        busys [3];

  int assertions = 0;
  int failures = 0;
  int latency [3] = '{5, 3, 2};
  int doneCnt [3];
  int doneAt [3];
  bit busyAt [3][64];
  logic [31:0] stimSave [4];

  always #5 clk = ~clk;

  aes_mixcolumns_multi #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start_in(start_in), .inv_in(inv_in),
    .state0(st[0]), .state1(st[1]), .state2(st[2]), .state3(st[3]),
    .state_out0(outs[0][0]), .state_out1(outs[0][1]),
    .state_out2(outs[0][2]), .state_out3(outs[0][3]),
    .done(dones[0]), .busy(busys[0]));

  aes_mixcolumns_multi #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .reset(reset), .start_in(start_in), .inv_in(inv_in),
    .state0(st[0]), .state1(st[1]), .state2(st[2]), .state3(st[3]),
    .state_out0(outs[1][0]), .state_out1(outs[1][1]),
    .state_out2(outs[1][2]), .state_out3(outs[1][3]),
    .done(dones[1]), .busy(busys[1]));

  aes_mixcolumns_multi #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset(reset), .start_in(start_in), .inv_in(inv_in),
    .state0(st[0]), .state1(st[1]), .state2(st[2]), .state3(st[3]),
    .state_out0(outs[2][0]), .state_out1(outs[2][1]),
    .state_out2(outs[2][2]), .state_out3(outs[2][3]),
    .done(dones[2]), .busy(busys[2]));

  // Generic GF(2^8) product by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  // Matrix-vector product of one column with the circulant coefficients.
  function automatic logic [31:0] modelCol(input logic [31:0] c, input logic inv);
    logic [7:0] coef [4];
    logic [7:0] o;
    logic [31:0] res;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    res = '0;
    for (int r = 0; r < 4; r++) begin
      o = 8'h00;
      for (int j = 0; j < 4; j++) begin
        o = o ^ gmul(coef[j], c[8*((r+j)%4) +: 8]);
      end
      res[8*r +: 8] = o;
    end
    return res;
  endfunction

  // Drives one start edge and watches done/busy for a bounded window.
  // scrambleAt >= 0 replaces the data inputs after that many edges.
  task automatic runOp(input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input logic [31:0] a3,
                       input logic inv, input int window, input int scrambleAt);
    st[0] = a0; st[1] = a1; st[2] = a2; st[3] = a3;
    inv_in = inv;
    start_in = 1'b1;
    for (int d = 0; d < 3; d++) begin
      doneCnt[d] = 0;
      doneAt[d] = -1;
    end
    for (int j = 0; j < window; j++) begin
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        busyAt[d][j] = busys[d];
        if (dones[d]) begin
          doneCnt[d]++;
          if (doneAt[d] < 0) doneAt[d] = j;
        end
      end
      if (j == scrambleAt) begin
        for (int i = 0; i < 4; i++) st[i] = $urandom;
        inv_in = ~inv_in;
      end
    end
  endtask

  task automatic dropStart();
    start_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) begin
        assertions++;
        if (outs[d][i] !== 32'h0) begin
          failures++;
          $display("FAIL reset_out dut=%0d col=%0d got %h expected 00000000", d, i, outs[d][i]);
        end
      end
      assertions++;
      if (dones[d] !== 1'b0 || busys[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_flags dut=%0d got done=%b busy=%b expected 0 0", d, dones[d], busys[d]);
      end
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      assertions++;
      if (dones[d] !== 1'b0 || busys[d] !== 1'b0 || outs[d][0] !== 32'h0) begin
        failures++;
        $display("FAIL idle_after_reset dut=%0d got done=%b busy=%b out0=%h expected 0 0 0", d, dones[d], busys[d], outs[d][0]);
      end
    end
  endtask

  task automatic test_kat_forward();
    logic [31:0] expv [4];
    expv = '{32'hbca14d8e, 32'h9d58dc9f, 32'h01010101, 32'hc6c6c6c6};
    runOp(32'h455313db, 32'h5c220af2, 32'h01010101, 32'hc6c6c6c6, 1'b0, 12, -1);
    for (int d = 0; d < 3; d++) begin
      assertions++;
      if (doneCnt[d] !== 1 || doneAt[d] !== latency[d]) begin
        failures++;
        $display("FAIL kat_done_timing dut=%0d got count=%0d at=%0d expected count=1 at=%0d", d, doneCnt[d], doneAt[d], latency[d]);
      end
      assertions++;
      if (busyAt[d][0] !== 1'b1 || busyAt[d][latency[d]-1] !== 1'b1 || busyAt[d][latency[d]] !== 1'b0) begin
        failures++;
        $display("FAIL kat_busy dut=%0d got first=%b last=%b after=%b expected 1 1 0", d, busyAt[d][0], busyAt[d][latency[d]-1], busyAt[d][latency[d]]);
      end
      for (int i = 0; i < 4; i++) begin
        assertions++;
        if (outs[d][i] !== expv[i]) begin
          failures++;
          $display("FAIL kat_out dut=%0d col=%0d got %h expected %h", d, i, outs[d][i], expv[i]);
        end
      end
    end
    dropStart();
  endtask

  task automatic test_second_vector();
    logic [31:0] expv [4];
    expv = '{32'hd6d7d5d5, 32'hf8bd7e4d, 32'h01010101, 32'hc6c6c6c6};
    runOp(32'hd5d4d4d4, 32'h4c31262d, 32'h01010101, 32'hc6c6c6c6, 1'b0, 12, -1);
    for (int d = 0; d < 3; d++) begin
      assertions++;
      if (doneCnt[d] !== 1) begin
        failures++;
        $display("FAIL vec2_done dut=%0d got %0d expected 1", d, doneCnt[d]);
      end
      for (int i = 0; i < 4; i++) begin
        assertions++;
        if (outs[d][i] !== expv[i]) begin
          failures++;
          $display("FAIL vec2_out dut=%0d col=%0d got %h expected %h", d, i, outs[d][i], expv[i]);
        end
      end
    end
    dropStart();
  endtask

  task automatic test_inverse();
    logic [31:0] inp [4];
    logic [31:0] invKat [4];
    logic [31:0] expv [4];
    inp = '{32'hbca14d8e, 32'h9d58dc9f, 32'h01010101, 32'hc6c6c6c6};
    invKat = '{32'h455313db, 32'h5c220af2, 32'h01010101, 32'hc6c6c6c6};
    for (int i = 0; i < 4; i++) expv[i] = INV_BUILT ? invKat[i] : modelCol(inp[i], 1'b0);
    runOp(inp[0], inp[1], inp[2], inp[3], 1'b1, 12, -1);
    for (int d = 0; d < 3; d++) begin
      assertions++;
      if (doneCnt[d] !== 1 || doneAt[d] !== latency[d]) begin
        failures++;
        $display("FAIL inv_done dut=%0d got count=%0d at=%0d expected count=1 at=%0d", d, doneCnt[d], doneAt[d], latency[d]);
      end
      for (int i = 0; i < 4; i++) begin
        assertions++;
        if (outs[d][i] !== expv[i]) begin
          failures++;
          $display("FAIL inv_out dut=%0d col=%0d got %h expected %h", d, i, outs[d][i], expv[i]);
        end
      end
    end
    dropStart();
  endtask

  task automatic test_random();
    logic [31:0] v [4];
    logic inv;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) v[i] = $urandom;
      inv = 1'($urandom_range(0, 1));
      runOp(v[0], v[1], v[2], v[3], inv, 10, -1);
      for (int d = 0; d < 3; d++) begin
        assertions++;
        if (doneCnt[d] !== 1 || doneAt[d] !== latency[d]) begin
          failures++;
          $display("FAIL rand_done n=%0d dut=%0d got count=%0d at=%0d expected count=1 at=%0d", n, d, doneCnt[d], doneAt[d], latency[d]);
        end
        for (int i = 0; i < 4; i++) begin
          assertions++;
          if (outs[d][i] !== modelCol(v[i], inv & INV_BUILT)) begin
            failures++;
            $display("FAIL rand_out n=%0d dut=%0d col=%0d got %h expected %h", n, d, i, outs[d][i], modelCol(v[i], inv & INV_BUILT));
          end
        end
      end
      dropStart();
    end
  endtask

  task automatic test_hold_start();
    runOp(32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210, 1'b0, 50, -1);
    for (int d = 0; d < 3; d++) begin
      assertions++;
      if (doneCnt[d] !== 1) begin
        failures++;
        $display("FAIL hold_start dut=%0d got %0d done pulses expected 1", d, doneCnt[d]);
      end
    end
    dropStart();
  endtask

  // Data inputs scrambled right after capture must not affect the result.
  task automatic test_input_change();
    logic [31:0] v [4];
    for (int i = 0; i < 4; i++) v[i] = $urandom;
    runOp(v[0], v[1], v[2], v[3], 1'b0, 12, 0);
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) begin
        assertions++;
        if (outs[d][i] !== modelCol(v[i], 1'b0)) begin
          failures++;
          $display("FAIL input_change dut=%0d col=%0d got %h expected %h", d, i, outs[d][i], modelCol(v[i], 1'b0));
        end
      end
    end
    dropStart();
  endtask

  // A fresh rising edge on start_in during the operation is ignored.
  task automatic test_busy_edge();
    logic [31:0] v [4];
    for (int i = 0; i < 4; i++) v[i] = $urandom;
    st[0] = v[0]; st[1] = v[1]; st[2] = v[2]; st[3] = v[3];
    inv_in = 1'b0;
    start_in = 1'b1;
    for (int d = 0; d < 3; d++) doneCnt[d] = 0;
    for (int j = 0; j < 16; j++) begin
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (dones[d]) doneCnt[d]++;
      if (j == 0) start_in = 1'b0;
      if (j == 1) start_in = 1'b1;
    end
    for (int d = 0; d < 3; d++) begin
      assertions++;
      if (doneCnt[d] !== 1) begin
        failures++;
        $display("FAIL busy_edge dut=%0d got %0d done pulses expected 1", d, doneCnt[d]);
      end
      assertions++;
      if (outs[d][3] !== modelCol(v[3], 1'b0)) begin
        failures++;
        $display("FAIL busy_edge_out dut=%0d got %h expected %h", d, outs[d][3], modelCol(v[3], 1'b0));
      end
    end
    dropStart();
  endtask

  // Start dropped for a single cycle after completion, then raised again.
  task automatic test_back_to_back();
    logic [31:0] v [4];
    runOp(32'h455313db, 32'h5c220af2, 32'h01010101, 32'hc6c6c6c6, 1'b0, 6, -1);
    dropStart();
    for (int i = 0; i < 4; i++) v[i] = $urandom;
    runOp(v[0], v[1], v[2], v[3], 1'b0, 8, -1);
    for (int d = 0; d < 3; d++) begin
      assertions++;
      if (doneCnt[d] !== 1 || doneAt[d] !== latency[d]) begin
        failures++;
        $display("FAIL back_to_back_done dut=%0d got count=%0d at=%0d expected count=1 at=%0d", d, doneCnt[d], doneAt[d], latency[d]);
      end
      assertions++;
      if (outs[d][0] !== modelCol(v[0], 1'b0) || outs[d][2] !== modelCol(v[2], 1'b0)) begin
        failures++;
        $display("FAIL back_to_back_out dut=%0d got %h %h expected %h %h", d, outs[d][0], outs[d][2], modelCol(v[0], 1'b0), modelCol(v[2], 1'b0));
      end
    end
    dropStart();
  endtask

  task automatic test_reset_midop();
    int doneSeen [3];
    st[0] = 32'hdeadbeef; st[1] = 32'h12345678; st[2] = 32'hcafef00d; st[3] = 32'h0badc0de;
    inv_in = 1'b0;
    start_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    start_in = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      doneSeen[d] = 0;
      assertions++;
      if (outs[d][0] !== 32'h0 || outs[d][1] !== 32'h0 || outs[d][2] !== 32'h0 ||
          outs[d][3] !== 32'h0 || dones[d] !== 1'b0 || busys[d] !== 1'b0) begin
        failures++;
        $display("FAIL midop_reset dut=%0d got %h %h %h %h done=%b busy=%b expected all zero", d, outs[d][0], outs[d][1], outs[d][2], outs[d][3], dones[d], busys[d]);
      end
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (dones[d]) doneSeen[d]++;
    end
    reset = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (dones[d]) doneSeen[d]++;
    end
    for (int d = 0; d < 3; d++) begin
      assertions++;
      if (doneSeen[d] !== 0) begin
        failures++;
        $display("FAIL midop_no_done dut=%0d got %0d done pulses expected 0", d, doneSeen[d]);
      end
    end
    runOp(32'h455313db, 32'h5c220af2, 32'h01010101, 32'hc6c6c6c6, 1'b0, 10, -1);
    for (int d = 0; d < 3; d++) begin
      assertions++;
      if (doneCnt[d] !== 1 || doneAt[d] !== latency[d] || outs[d][0] !== 32'hbca14d8e || outs[d][1] !== 32'h9d58dc9f) begin
        failures++;
        $display("FAIL midop_recover dut=%0d got count=%0d at=%0d out0=%h out1=%h expected 1 %0d bca14d8e 9d58dc9f", d, doneCnt[d], doneAt[d], outs[d][0], outs[d][1], latency[d]);
      end
    end
    dropStart();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) st[i] = 32'h0;
    test_reset();
    test_kat_forward();
    test_second_vector();
    test_inverse();
    test_random();
    test_hold_start();
    test_input_change();
    test_busy_edge();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
